game_info_keeper: RTL and testbench

GAME_INFO_KEEPER -- requirements
Module: game_info_keeper

---
 rtl/game_pkg.sv | 31 +++
 rtl/sat_score_adder.sv | 33 +++
 rtl/game_info_keeper.sv | 158 +++++++++++++++
 tb/tb_game_info_keeper.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game info keeper.
//   - Field widths for score, lives, level, dot count and the internal score sum.
//   - Default point values and limits used as parameter defaults.
//   - gameState_e: the life-cycle of one board.
package game_pkg;

  localparam int unsigned ScoreW = 14;
  localparam int unsigned HpW    = 2;
  localparam int unsigned LevelW = 4;
  localparam int unsigned DotsW  = 8;
  // One extra bit so the raw sum can exceed the score range before clamping.
  localparam int unsigned SumW   = 15;

  localparam int unsigned DefInitHp       = 3;
  localparam int unsigned DefTotalDots    = 150;
  localparam int unsigned DefInvulnCycles = 120;
  localparam int unsigned DefScoreMax     = 9999;
  localparam int unsigned DefDotPts       = 10;
  localparam int unsigned DefBigPts       = 50;
  localparam int unsigned DefGhostPts     = 200;
  localparam int unsigned DefMaxLevel     = 15;

  typedef enum logic [2:0] {
    StIdle,
    StActive,
    StHitLock,
    StDoneWin,
    StDoneLose
  } gameState_e;

endpackage

// File: rtl/sat_score_adder.sv
// sat_score_adder: adds the points of up to three simultaneous scoring events
// to the current score and clamps the result at SCORE_MAX.
//   score    in  current score
//   dotEn    in  add DOT_PTS
//   bigEn    in  add BIG_PTS
//   ghostEn  in  add GHOST_PTS
//   satScore out updated score, never above SCORE_MAX
module sat_score_adder
  import game_pkg::*;
#(
  parameter int unsigned DOT_PTS   = DefDotPts,
  parameter int unsigned BIG_PTS   = DefBigPts,
  parameter int unsigned GHOST_PTS = DefGhostPts,
  parameter int unsigned SCORE_MAX = DefScoreMax
) (
  input  logic [ScoreW-1:0] score,
  input  logic              dotEn,
  input  logic              bigEn,
  input  logic              ghostEn,
  output logic [ScoreW-1:0] satScore
);

  logic [SumW-1:0] sum;

  always_comb begin
    sum = {1'b0, score};
    if (dotEn)   sum = sum + SumW'(DOT_PTS);
    if (bigEn)   sum = sum + SumW'(BIG_PTS);
    if (ghostEn) sum = sum + SumW'(GHOST_PTS);
    satScore = (sum > SumW'(SCORE_MAX)) ? ScoreW'(SCORE_MAX) : sum[ScoreW-1:0];
  end

endmodule

// File: rtl/game_info_keeper.sv
// game_info_keeper: keeps score, lives, level and remaining dots for one game and
// tracks the board life-cycle (idle, playing, post-hit lockout, won, lost).
//   clk        in  system clock
//   resetN     in  synchronous reset, 1 = reset
//   initGame   in  load a fresh board and return to idle
//   playGame   in  game running; gates all event counting
//   resetInfo  in  clear score, restore lives, back to level 1
//   nextLevel  in  advance one level per rising edge
//   dotEaten, bigDotEaten, ghostEaten, pacmanHit  in  event pulses
//   score, hp, level, dotsLeft  out  registered game counters
//   respawn    out one-cycle pulse after a non-fatal hit
//   win, lose  out held while the board is won / lost
module game_info_keeper
  import game_pkg::*;
#(
  parameter int unsigned INIT_HP       = DefInitHp,
  parameter int unsigned TOTAL_DOTS    = DefTotalDots,
  parameter int unsigned INVULN_CYCLES = DefInvulnCycles,
  parameter int unsigned SCORE_MAX     = DefScoreMax,
  parameter int unsigned DOT_PTS       = DefDotPts,
  parameter int unsigned BIG_PTS       = DefBigPts,
  parameter int unsigned GHOST_PTS     = DefGhostPts,
  parameter int unsigned MAX_LEVEL     = DefMaxLevel
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              initGame,
  input  logic              playGame,
  input  logic              resetInfo,
  input  logic              nextLevel,
  input  logic              dotEaten,
  input  logic              bigDotEaten,
  input  logic              ghostEaten,
  input  logic              pacmanHit,
  output logic [ScoreW-1:0] score,
  output logic [HpW-1:0]    hp,
  output logic [LevelW-1:0] level,
  output logic [DotsW-1:0]  dotsLeft,
  output logic              respawn,
  output logic              win,
  output logic              lose
);

  localparam int unsigned TimerW = $clog2(INVULN_CYCLES + 1);

  gameState_e        state, stateNext;
  logic [TimerW-1:0] timer, timerNext;
  logic              nextLevelPrev;

  logic              eventsOn;
  logic              dotCnt, bigCnt, ghostCnt;
  logic [1:0]        dotDec;
  logic [DotsW-1:0]  dotsAfter;
  logic              lastDot;
  logic              hitTaken;
  logic              lastLife;
  logic              nextLevelRise;
  logic [ScoreW-1:0] scoreSum;

  // initGame overrides everything else in its cycle, including events.
  assign eventsOn = playGame && !initGame && (state == StActive || state == StHitLock);
  assign dotCnt   = eventsOn && dotEaten;
  assign bigCnt   = eventsOn && bigDotEaten;
  assign ghostCnt = eventsOn && ghostEaten;

  assign dotDec    = {1'b0, dotCnt} + {1'b0, bigCnt};
  assign dotsAfter = (dotsLeft > {{(DotsW-2){1'b0}}, dotDec}) ?
                     dotsLeft - {{(DotsW-2){1'b0}}, dotDec} : '0;
  assign lastDot   = (dotCnt || bigCnt) && (dotsAfter == '0);

  // Clearing the board wins over a simultaneous hit.
  assign hitTaken      = eventsOn && pacmanHit && (state == StActive) && !lastDot;
  assign lastLife      = (hp <= 2'd1);
  assign nextLevelRise = nextLevel && !nextLevelPrev;

  sat_score_adder #(
    .DOT_PTS   (DOT_PTS),
    .BIG_PTS   (BIG_PTS),
    .GHOST_PTS (GHOST_PTS),
    .SCORE_MAX (SCORE_MAX)
  ) u_sat_score_adder (
    .score    (score),
    .dotEn    (dotCnt),
    .bigEn    (bigCnt),
    .ghostEn  (ghostCnt),
    .satScore (scoreSum)
  );

  always_comb begin
    stateNext = state;
    timerNext = timer;
    unique case (state)
      StIdle: begin
        if (playGame) stateNext = StActive;
      end
      StActive: begin
        if (lastDot) begin
          stateNext = StDoneWin;
        end else if (hitTaken) begin
          if (lastLife) begin
            stateNext = StDoneLose;
          end else begin
            stateNext = StHitLock;
            timerNext = TimerW'(INVULN_CYCLES);
          end
        end
      end
      StHitLock: begin
        timerNext = (timer != '0) ? timer - 1'b1 : '0;
        if (lastDot) begin
          stateNext = StDoneWin;
          timerNext = '0;
        end else if (timerNext == '0) begin
          stateNext = StActive;
        end
      end
      StDoneWin, StDoneLose: ;
      default: stateNext = StIdle;
    endcase
    if (initGame) begin
      stateNext = StIdle;
      timerNext = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state         <= StIdle;
      timer         <= '0;
      nextLevelPrev <= 1'b0;
      score         <= '0;
      hp            <= HpW'(INIT_HP);
      level         <= LevelW'(1);
      dotsLeft      <= DotsW'(TOTAL_DOTS);
      respawn       <= 1'b0;
      win           <= 1'b0;
      lose          <= 1'b0;
    end else begin
      state         <= stateNext;
      timer         <= timerNext;
      nextLevelPrev <= nextLevel;
      respawn       <= hitTaken && !lastLife;
      win           <= (stateNext == StDoneWin);
      lose          <= (stateNext == StDoneLose);
      dotsLeft      <= initGame ? DotsW'(TOTAL_DOTS) : dotsAfter;
      if (resetInfo) begin
        score <= '0;
        hp    <= HpW'(INIT_HP);
        level <= LevelW'(1);
      end else begin
        score <= scoreSum;
        if (hitTaken) hp <= lastLife ? '0 : hp - 2'd1;
        if (nextLevelRise && level < LevelW'(MAX_LEVEL)) level <= level + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_info_keeper.sv
// Scoreboard bench for game_info_keeper: a driver applies stimulus on the falling
// edge and pushes the reference model's expected outputs; a monitor pops and
// compares after every rising edge.
module tb_game_info_keeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN = 1'b1, initGame = 1'b0, playGame = 1'b0, resetInfo = 1'b0, nextLevel = 1'b0;
  logic dotEaten = 1'b0, bigDotEaten = 1'b0, ghostEaten = 1'b0, pacmanHit = 1'b0;
  logic [13:0] score;
  logic [1:0]  hp;
  logic [3:0]  level;
  logic [7:0]  dotsLeft;
  logic        respawn, win, lose;

  game_info_keeper dut (
    .clk         (clk),
    .resetN      (resetN),
    .initGame    (initGame),
    .playGame    (playGame),
    .resetInfo   (resetInfo),
    .nextLevel   (nextLevel),
    .dotEaten    (dotEaten),
    .bigDotEaten (bigDotEaten),
    .ghostEaten  (ghostEaten),
    .pacmanHit   (pacmanHit),
    .score       (score),
    .hp          (hp),
    .level       (level),
    .dotsLeft    (dotsLeft),
    .respawn     (respawn),
    .win         (win),
    .lose        (lose)
  );

  typedef struct packed {
    logic rst, init, play, rinfo, nl, dot, big, ghost, hit;
  } stim_t;

  typedef struct packed {
    logic [13:0] score;
    logic [1:0]  hp;
    logic [3:0]  level;
    logic [7:0]  dots;
    logic        respawn, win, lose;
  } out_t;

  out_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: game phase plus plain integer counters.
  localparam int PhIdle = 0, PhActive = 1, PhLock = 2, PhWon = 3, PhLost = 4;
  int mPhase, mScore, mHp, mLevel, mDots, mLock;
  bit mPrevNl, mResp;

  task automatic modelStep(input stim_t s);
    int  pts, eaten, newDots;
    bit  counting, cleared, hit;
    out_t e;
    mResp = 1'b0;
    if (s.rst) begin
      mPhase = PhIdle; mScore = 0; mHp = 3; mLevel = 1; mDots = 150; mLock = 0;
      mPrevNl = 1'b0;
    end else begin
      counting = !s.init && s.play && (mPhase == PhActive || mPhase == PhLock);
      pts = 0; eaten = 0;
      if (counting && s.dot)   begin pts += 10; eaten++; end
      if (counting && s.big)   begin pts += 50; eaten++; end
      if (counting && s.ghost) pts += 200;
      newDots = (mDots > eaten) ? mDots - eaten : 0;
      cleared = (eaten > 0) && (newDots == 0);
      hit     = counting && s.hit && (mPhase == PhActive) && !cleared;
      if (s.init) begin
        mPhase = PhIdle; mLock = 0;
      end else begin
        case (mPhase)
          PhIdle:   if (s.play) mPhase = PhActive;
          PhActive: begin
            if (cleared) mPhase = PhWon;
            else if (hit) begin
              if (mHp <= 1) mPhase = PhLost;
              else begin mPhase = PhLock; mLock = 120; mResp = 1'b1; end
            end
          end
          PhLock: begin
            mLock--;
            if (cleared) begin mPhase = PhWon; mLock = 0; end
            else if (mLock == 0) mPhase = PhActive;
          end
          default: ;
        endcase
      end
      mDots = s.init ? 150 : newDots;
      if (s.rinfo) begin
        mScore = 0; mHp = 3; mLevel = 1;
      end else begin
        mScore = (mScore + pts > 9999) ? 9999 : mScore + pts;
        if (hit) mHp = (mHp <= 1) ? 0 : mHp - 1;
        if (s.nl && !mPrevNl && mLevel < 15) mLevel++;
      end
      mPrevNl = s.nl;
    end
    e.score   = 14'(mScore);
    e.hp      = 2'(mHp);
    e.level   = 4'(mLevel);
    e.dots    = 8'(mDots);
    e.respawn = mResp;
    e.win     = (mPhase == PhWon);
    e.lose    = (mPhase == PhLost);
    expQ.push_back(e);
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    resetN = s.rst; initGame = s.init; playGame = s.play; resetInfo = s.rinfo;
    nextLevel = s.nl; dotEaten = s.dot; bigDotEaten = s.big; ghostEaten = s.ghost;
    pacmanHit = s.hit;
    modelStep(s);
  endtask

  function automatic stim_t ev(input bit dot, input bit big, input bit ghost, input bit hit);
    stim_t s;
    s = '0; s.play = 1'b1; s.dot = dot; s.big = big; s.ghost = ghost; s.hit = hit;
    return s;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(ev(1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Monitor: one expected entry per rising edge once stimulus has started.
  initial begin
    out_t got, e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e   = expQ.pop_front();
        got = '{score, hp, level, dotsLeft, respawn, win, lose};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got score=%0d hp=%0d level=%0d dots=%0d resp=%b win=%b lose=%b want score=%0d hp=%0d level=%0d dots=%0d resp=%b win=%b lose=%b",
                   $time, got.score, got.hp, got.level, got.dots, got.respawn, got.win,
                   got.lose, e.score, e.hp, e.level, e.dots, e.respawn, e.win, e.lose);
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;

    s = '0; s.rst = 1'b1;
    repeat (3) step(s);
    s = '0; s.init = 1'b1;
    step(s);

    // Three dots, a combined dot+big, a ghost.
    idle(1);
    repeat (3) begin step(ev(1, 0, 0, 0)); idle(1); end
    step(ev(1, 1, 0, 0));
    step(ev(0, 0, 1, 0));

    // Hit, ignored re-hit during lockout, then two more hits to lose.
    step(ev(0, 0, 0, 1));
    idle(9);
    step(ev(0, 0, 0, 1));
    step(ev(1, 0, 1, 0));
    idle(114);
    step(ev(0, 0, 0, 1));
    idle(125);
    step(ev(0, 0, 0, 1));
    repeat (3) step(ev(1, 1, 1, 1));

    // Score saturation from a fresh board.
    s = '0; s.rinfo = 1'b1; step(s);
    s = '0; s.init = 1'b1; step(s);
    repeat (60) step(ev(0, 0, 1, 0));

    // Clear the board with the last dot coinciding with a hit.
    s = '0; s.init = 1'b1; step(s);
    idle(1);
    guard = 0;
    while (mDots > 1 && guard < 400) begin step(ev(1, 0, 0, 0)); guard++; end
    step(ev(1, 0, 0, 1));
    repeat (3) step(ev(1, 0, 1, 1));

    // Floor at zero: dot+big when only one dot remains.
    s = '0; s.init = 1'b1; step(s);
    idle(1);
    guard = 0;
    while (mDots > 1 && guard < 400) begin step(ev(0, 1, 0, 0)); guard++; end
    step(ev(1, 1, 0, 0));
    idle(2);

    // Level edges held for several cycles, past the cap, then resetInfo.
    for (int i = 0; i < 17; i++) begin
      s = '0; s.nl = 1'b1;
      repeat (3) step(s);
      s = '0;
      repeat (2) step(s);
    end
    s = '0; s.rinfo = 1'b1;
    repeat (2) step(s);

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      s       = '0;
      s.rst   = ($urandom_range(0, 199) == 0);
      s.init  = ($urandom_range(0, 149) == 0);
      s.play  = ($urandom_range(0, 9) != 0);
      s.nl    = ($urandom_range(0, 19) == 0);
      s.dot   = ($urandom_range(0, 2) == 0);
      s.big   = ($urandom_range(0, 9) == 0);
      s.ghost = ($urandom_range(0, 7) == 0);
      s.hit   = ($urandom_range(0, 29) == 0);
      if (!(s.dot || s.big || s.ghost || s.hit)) s.rinfo = ($urandom_range(0, 49) == 0);
      step(s);
    end

    s = '0;
    step(s);
    repeat (3) @(negedge clk);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
